mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data port, downstream of the single-cycle core.
- Consumes MemWrite, dAddr and WriteData; returns read data through the core's dMemData mux (ORed with data RAM read data).
- Buffers bytes in a FIFO and serialises them 8N1 on a tx pin.
- Reads are combinational and writes are registered, so the single-cycle core never needs to stall.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/mmio_uart_tx_fifo.sv | 62 ++++++
 rtl/mmio_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions and the transmit FSM states.
package uart_pkg;

    localparam logic [3:0] TXDATA_OFF  = 4'h0;
    localparam logic [3:0] STATUS_OFF  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFF = 4'h8;
    localparam logic [3:0] CTRL_OFF    = 4'hC;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [4:0] cnt
    );
        pack_status = {23'd0, cnt, ovf, busy, empty, full};
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, baud counter and
// framing FSM in front of a byte FIFO. Reads are combinational, writes registered.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] dAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            hit_s;
    logic            wr_s;
    logic [3:0]      off_s;
    logic            push_s;
    logic            pop_s;
    logic            can_start_s;
    logic            baud_done_s;
    logic [7:0]      fifo_dout_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic            unused_bits_s;

    logic            en_r;
    logic            ie_r;
    logic            ovf_r;
    logic [15:0]     div_r;
    tx_state_t       state_r;
    logic [15:0]     baud_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            irq_r;

    assign hit_s         = (dAddr[31:4] == BASE_ADDR[31:4]);
    assign off_s         = {dAddr[3:2], 2'b00};
    assign wr_s          = MemWrite && hit_s;
    assign push_s        = wr_s && (off_s == TXDATA_OFF);
    assign can_start_s   = en_r && !fifo_empty_s;
    assign baud_done_s   = (baud_r == 16'd0);
    assign unused_bits_s = ^{dAddr[1:0], WriteData[31:16]};

    assign hit = hit_s;
    assign tx  = tx_r;
    assign irq = irq_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (WriteData[7:0]),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Pop when a new frame begins, either from IDLE or straight out of STOP.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = can_start_s;
            STOP:    pop_s = baud_done_s && can_start_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Combinational read mux; zero outside the window so it can be ORed with RAM data.
    always_comb begin
        rdata = 32'd0;
        if (hit_s) begin
            case (off_s)
                STATUS_OFF:  rdata = pack_status(fifo_full_s, fifo_empty_s,
                                                 (state_r != IDLE), ovf_r,
                                                 5'(fifo_count_s));
                BAUDDIV_OFF: rdata = {16'd0, div_r};
                CTRL_OFF:    rdata = {30'd0, ie_r, en_r};
                default:     rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

    // Software-visible control registers and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r  <= 1'b0;
            ie_r  <= 1'b0;
            div_r <= DEFAULT_DIV;
            ovf_r <= 1'b0;
        end else begin
            if (wr_s && (off_s == CTRL_OFF)) begin
                en_r <= WriteData[CTRL_EN];
                ie_r <= WriteData[CTRL_IE];
            end
            if (wr_s && (off_s == BAUDDIV_OFF)) begin
                div_r <= WriteData[15:0];
            end
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (wr_s && (off_s == STATUS_OFF) && WriteData[ST_OVF]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Framing FSM; BAUDDIV is sampled only on counter reloads so bits never stretch mid-way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (can_start_s) begin
                        shift_r <= fifo_dout_s;
                        baud_r  <= div_r;
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end
                end
                START: begin
                    if (baud_done_s) begin
                        baud_r    <= div_r;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= DATA;
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done_s) begin
                        baud_r <= div_r;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done_s) begin
                        if (can_start_s) begin
                            shift_r <= fifo_dout_s;
                            baud_r  <= div_r;
                            tx_r    <= 1'b0;
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    // Interrupt when the FIFO has drained and interrupts are enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ie_r && fifo_empty_s;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes
// 8N1 frames cycle by cycle and compares against the queue.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [3:0] O_TX = 4'h0, O_ST = 4'h4, O_BD = 4'h8, O_CT = 4'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] dAddr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] rdata;
    logic        hit, tx, irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int          cur_div = 867;
    bit          mon_busy = 1'b0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];

    mmio_uart_tx dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .dAddr(dAddr),
        .WriteData(WriteData), .rdata(rdata), .hit(hit), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        @(negedge clk);
        MemWrite = 1'b1; dAddr = BASE | {28'd0, off}; WriteData = d;
        @(posedge clk); #1;
        MemWrite = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) exp_q.push_back(b);
        wr(O_TX, {24'd0, b});
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v);
        @(negedge clk);
        MemWrite = 1'b0; dAddr = addr;
        #1 v = rdata;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] v;
        rd(BASE | {28'd0, off}, v);
        chk(name, v, exp);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk); n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL drain: %0d bytes still pending after %0d cycles, required 0", exp_q.size(), budget);
        end
    endtask

    // Decode one frame; each of the 10 bit slots must hold a constant level for cur_div+1 cycles.
    task automatic mon_frame();
        logic [9:0] lv = 10'd0;
        bit ok = 1'b1, ab = 1'b0;
        int p = cur_div + 1;
        logic [7:0] e;
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        #1;
        for (int b = 0; b < 10 && !ab; b++) begin
            for (int c = 0; c < p && !ab; c++) begin
                if (b != 0 || c != 0) begin
                    @(posedge clk); #1;
                end
                if (!reset) ab = 1'b1;
                else if (c == 0) lv[b] = tx;
                else if (tx !== lv[b]) ok = 1'b0;
            end
        end
        if (!ab) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL frame: got unexpected byte 0x%02h, required no frame", lv[8:1]);
            end else begin
                e = exp_q.pop_front();
                if (!ok || lv[0] !== 1'b0 || lv[9] !== 1'b1 || lv[8:1] !== e) begin
                    n_bad++;
                    $display("FAIL frame: got byte 0x%02h start %b stop %b stable %0d, required 0x%02h", lv[8:1], lv[0], lv[9], ok, e);
                end
            end
        end
        mon_busy = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge tx);
            if (reset) mon_frame();
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        int          d, nb;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        rd_chk("reset_status", O_ST, 32'h0000_0002);
        rd_chk("reset_bauddiv", O_BD, 32'd867);
        rd_chk("reset_ctrl", O_CT, 32'd0);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rd(BASE + 32'h10, v);
        chk("outside_rdata", v, 32'd0);
        chk("outside_hit", {31'd0, hit}, 32'd0);
        rd(BASE + 32'h18, v);
        chk("outside_alias_rdata", v, 32'd0);
        rd(BASE + 32'h4, v);
        chk("inside_hit", {31'd0, hit}, 32'd1);

        // Single frame 0xA5 at 4 cycles per bit, with latency check
        wr(O_BD, 32'd3); cur_div = 3;
        wr(O_CT, 32'd3);
        push_byte(8'hA5, 1'b1);
        chk("latency_edge_n", {31'd0, tx}, 32'd1);
        @(posedge clk); #1;
        chk("latency_edge_n1", {31'd0, tx}, 32'd0);
        drain(200);
        repeat (3) @(posedge clk);
        rd_chk("after_frame_status", O_ST, 32'h0000_0002);
        chk("after_frame_irq", {31'd0, irq}, 32'd1);

        // Back-to-back frames at 1 cycle per bit: no idle gap
        wr(O_BD, 32'd0); cur_div = 0;
        start_q.delete();
        push_byte(8'h55, 1'b1);
        push_byte(8'h0F, 1'b1);
        drain(100);
        chk("b2b_frames", start_q.size(), 32'd2);
        if (start_q.size() >= 2) chk("b2b_spacing", start_q[1] - start_q[0], 32'd10);

        // Overflow with transmitter disabled; ninth byte must never appear
        wr(O_CT, 32'd2);
        for (int i = 0; i < 9; i++) push_byte(8'h30 + 8'(i), (i < 8));
        rd_chk("ovf_status", O_ST, 32'h0000_0089);
        wr(O_ST, 32'h8);
        rd_chk("ovf_cleared", O_ST, 32'h0000_0081);
        wr(O_BD, 32'd1); cur_div = 1;
        wr(O_CT, 32'd3);
        drain(400);
        repeat (40) @(posedge clk);
        rd_chk("ovf_drained", O_ST, 32'h0000_0002);

        // Push into a full FIFO on the same edge the FSM pops
        wr(O_CT, 32'd2);
        for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i), 1'b1);
        wr(O_CT, 32'd3);
        push_byte(8'h99, 1'b1);
        rd_chk("same_edge_status", O_ST, 32'h0000_0085);
        drain(400);

        // Randomised traffic against the scoreboard
        for (int it = 0; it < 12; it++) begin
            drain(2000);
            d = $urandom_range(0, 4);
            wr(O_BD, d); cur_div = d;
            rd_chk("rand_bauddiv", O_BD, d);
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                repeat ($urandom_range(0, 30 * (d + 1))) @(posedge clk);
                b = 8'($urandom);
                push_byte(b, 1'b1);
            end
        end
        drain(2000);

        // Reset in the middle of data bit 3 of 0xC3 (bit 3 = 0)
        wr(O_BD, 32'd3); cur_div = 3;
        push_byte(8'hC3, 1'b1);
        @(posedge clk);
        repeat (17) @(posedge clk);
        #2 reset = 1'b0;
        exp_q.delete();
        #1 chk("reset_midframe_tx", {31'd0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start_q.delete();
        rd_chk("post_reset_status", O_ST, 32'h0000_0002);
        rd_chk("post_reset_ctrl", O_CT, 32'd0);
        rd_chk("post_reset_bauddiv", O_BD, 32'd867);
        repeat (100) @(posedge clk);
        #1;
        chk("post_reset_no_frames", start_q.size(), 32'd0);
        chk("post_reset_tx_idle", {31'd0, tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
